store_sequencer: RTL and testbench

//  Sequences CPU store requests (sb/sh/sw) onto the word-wide data-memory write port.

---
 rtl/store_sequencer_if.sv | 26 ++
 rtl/store_sequencer.sv | 168 ++++++++++++++++
 tb/tb_store_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/store_sequencer_if.sv
// Store-sequencer handshake bundle: request side from store-issue logic,
// write-beat side toward DMEM/IO, plus the done/err completion pulses.
interface store_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic        done;
  logic        err;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wen, done, err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wen, done, err
  );
endinterface

// File: rtl/store_sequencer.sv
// Sequences sb/sh/sw stores onto a word-wide write port: lane alignment,
// byte-enable generation and splitting of word-crossing stores into two beats.
module store_sequencer #(
  parameter bit ALLOW_SPLIT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  store_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10
  } state_t;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        r[8*i +: 8] = d[8*i +: 8];
      end else begin
        r[8*i +: 8] = 8'h00;
      end
    end
    return r;
  endfunction

  state_t      state_q,     state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wen_q,   mem_wen_d;
  logic [31:0] hi_wdata_q,  hi_wdata_d;
  logic [3:0]  hi_wen_q,    hi_wen_d;
  logic        done_q,      done_d;
  logic        err_q,       err_d;

  logic [3:0]  mask_s;
  logic [7:0]  lanes8_s;
  logic [63:0] data64_s;
  logic        need2_s;
  logic        reject_s;
  logic        accept_s;
  logic        beat_hs_s;

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Request decode, next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = mem_wen_q;
    hi_wdata_d  = hi_wdata_q;
    hi_wen_d    = hi_wen_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    mask_s    = size_mask(bus.req_size);
    lanes8_s  = {4'b0000, mask_s} << bus.req_addr[1:0];
    data64_s  = {32'h0000_0000, lane_data(bus.req_data, mask_s)} << {bus.req_addr[1:0], 3'b000};
    need2_s   = |lanes8_s[7:4];
    reject_s  = (bus.req_size == 2'b11) || (need2_s && !ALLOW_SPLIT);
    accept_s  = bus.req_valid && (state_q == IDLE);
    beat_hs_s = mem_valid_q && bus.mem_ready;

    case (state_q)
      IDLE: begin
        if (accept_s && reject_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          state_d     = BEAT0;
          mem_valid_d = 1'b1;
          mem_addr_d  = {bus.req_addr[31:2], 2'b00};
          mem_wen_d   = lanes8_s[3:0];
          mem_wdata_d = data64_s[31:0];
          hi_wen_d    = lanes8_s[7:4];
          hi_wdata_d  = data64_s[63:32];
        end else begin
          state_d = IDLE;
        end
      end
      BEAT0: begin
        // A non-zero upper lane set means the store crossed into the next word
        if (beat_hs_s && (hi_wen_q != 4'b0000)) begin
          state_d     = BEAT1;
          mem_addr_d  = mem_addr_q + 32'd4;
          mem_wen_d   = hi_wen_q;
          mem_wdata_d = hi_wdata_q;
        end else if (beat_hs_s) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wen_d   = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
          done_d      = 1'b1;
        end else begin
          state_d = BEAT0;
        end
      end
      BEAT1: begin
        if (beat_hs_s) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_addr_d  = 32'h0000_0000;
          mem_wen_d   = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
          done_d      = 1'b1;
        end else begin
          state_d = BEAT1;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        mem_addr_d  = 32'h0000_0000;
        mem_wen_d   = 4'b0000;
        mem_wdata_d = 32'h0000_0000;
      end
    endcase
  end

  // State and registered-output flops; reset drops any in-flight store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_wen_q   <= 4'b0000;
      hi_wdata_q  <= 32'h0000_0000;
      hi_wen_q    <= 4'b0000;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
      hi_wdata_q  <= hi_wdata_d;
      hi_wen_q    <= hi_wen_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: one split-enabled and one split-disabled instance.
module tb_store_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  store_sequencer_if bus1();
  store_sequencer_if bus0();

  store_sequencer #(.ALLOW_SPLIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  store_sequencer #(.ALLOW_SPLIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input string tag, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    chk1({tag, "_valid"}, bus1.mem_valid, 1'b1);
    chk32({tag, "_addr"}, bus1.mem_addr, a);
    chk32({tag, "_wen"}, {28'h0, bus1.mem_wen}, {28'h0, w});
    chk32({tag, "_wdata"}, bus1.mem_wdata, d);
    chk1({tag, "_done"}, bus1.done, 1'b0);
    chk1({tag, "_rdy"}, bus1.req_ready, 1'b0);
  endtask

  task automatic idle1(input string tag, input logic done_exp);
    chk1({tag, "_valid"}, bus1.mem_valid, 1'b0);
    chk32({tag, "_wen"}, {28'h0, bus1.mem_wen}, 32'h0000_0000);
    chk32({tag, "_wdata"}, bus1.mem_wdata, 32'h0000_0000);
    chk1({tag, "_done"}, bus1.done, done_exp);
    chk1({tag, "_err"}, bus1.err, 1'b0);
    chk1({tag, "_rdy"}, bus1.req_ready, 1'b1);
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus1.req_valid = 1'b1;
    bus1.req_addr  = a;
    bus1.req_data  = d;
    bus1.req_size  = s;
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    bus0.req_valid = 1'b1;
    bus0.req_addr  = a;
    bus0.req_data  = d;
    bus0.req_size  = s;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus1.req_valid = 1'b0;
    bus1.req_addr  = 32'h0;
    bus1.req_data  = 32'h0;
    bus1.req_size  = 2'b00;
    bus1.mem_ready = 1'b1;
    bus0.req_valid = 1'b0;
    bus0.req_addr  = 32'h0;
    bus0.req_data  = 32'h0;
    bus0.req_size  = 2'b00;
    bus0.mem_ready = 1'b1;

    // reset state
    #2;
    idle1("rst", 1'b0);
    chk32("rst_addr", bus1.mem_addr, 32'h0000_0000);
    chk1("rst_rdy0", bus0.req_ready, 1'b1);
    #6;
    rst_n = 1'b1;
    step();

    // sb at offset 2, then back-to-back sh in the done cycle
    drive1(32'h0000_1002, 32'hFFFF_FFAB, 2'b00);
    chk1("sb_rdy", bus1.req_ready, 1'b1);
    step();
    bus1.req_valid = 1'b0;
    beat1("sb_b0", 32'h0000_1000, 4'b0100, 32'h00AB_0000);
    step();
    idle1("sb_done", 1'b1);
    drive1(32'h0000_4002, 32'h0000_5566, 2'b01);
    step();
    bus1.req_valid = 1'b0;
    beat1("b2b_b0", 32'h0000_4000, 4'b1100, 32'h5566_0000);
    step();
    idle1("b2b_done", 1'b1);
    step();
    idle1("b2b_after", 1'b0);

    // sw crossing a word: two beats, single done
    drive1(32'h0000_1003, 32'h1122_3344, 2'b10);
    step();
    bus1.req_valid = 1'b0;
    beat1("swx_b0", 32'h0000_1000, 4'b1000, 32'h4400_0000);
    step();
    beat1("swx_b1", 32'h0000_1004, 4'b0111, 32'h0011_2233);
    step();
    idle1("swx_done", 1'b1);
    step();
    idle1("swx_after", 1'b0);

    // sh with memory stalled for 5 cycles
    drive1(32'h0000_2001, 32'h1234_BEEF, 2'b01);
    bus1.mem_ready = 1'b0;
    step();
    bus1.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat1("stall", 32'h0000_2000, 4'b0110, 32'h00BE_EF00);
      step();
    end
    bus1.mem_ready = 1'b1;
    beat1("stall_rel", 32'h0000_2000, 4'b0110, 32'h00BE_EF00);
    step();
    idle1("stall_done", 1'b1);
    step();

    // sw crossing the top of the address space wraps to 0
    drive1(32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10);
    step();
    bus1.req_valid = 1'b0;
    beat1("wrap_b0", 32'hFFFF_FFFC, 4'b1100, 32'hCCDD_0000);
    step();
    beat1("wrap_b1", 32'h0000_0000, 4'b0011, 32'h0000_AABB);
    step();
    idle1("wrap_done", 1'b1);
    step();

    // split disabled: crossing store rejected, aligned store accepted
    drive0(32'h0000_3001, 32'h0102_0304, 2'b10);
    step();
    bus0.req_valid = 1'b0;
    chk1("ns_err", bus0.err, 1'b1);
    chk1("ns_err_valid", bus0.mem_valid, 1'b0);
    chk1("ns_err_done", bus0.done, 1'b0);
    chk1("ns_err_rdy", bus0.req_ready, 1'b1);
    step();
    chk1("ns_err_clr", bus0.err, 1'b0);
    chk1("ns_err_valid2", bus0.mem_valid, 1'b0);
    drive0(32'h0000_3000, 32'hDEAD_BEEF, 2'b10);
    step();
    bus0.req_valid = 1'b0;
    chk1("ns_sw_valid", bus0.mem_valid, 1'b1);
    chk32("ns_sw_addr", bus0.mem_addr, 32'h0000_3000);
    chk32("ns_sw_wen", {28'h0, bus0.mem_wen}, 32'h0000_000F);
    chk32("ns_sw_wdata", bus0.mem_wdata, 32'hDEAD_BEEF);
    step();
    chk1("ns_sw_done", bus0.done, 1'b1);
    chk1("ns_sw_valid2", bus0.mem_valid, 1'b0);
    step();

    // illegal size rejected by both builds
    drive0(32'h0000_5000, 32'h1111_1111, 2'b11);
    drive1(32'h0000_5000, 32'h1111_1111, 2'b11);
    step();
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
    chk1("sz11_err0", bus0.err, 1'b1);
    chk1("sz11_err1", bus1.err, 1'b1);
    chk1("sz11_valid0", bus0.mem_valid, 1'b0);
    chk1("sz11_valid1", bus1.mem_valid, 1'b0);
    chk1("sz11_done1", bus1.done, 1'b0);
    step();
    chk1("sz11_clr1", bus1.err, 1'b0);

    // reset asserted during the second beat of a split store
    drive1(32'h0000_1003, 32'h1122_3344, 2'b10);
    step();
    bus1.req_valid = 1'b0;
    beat1("rsx_b0", 32'h0000_1000, 4'b1000, 32'h4400_0000);
    step();
    beat1("rsx_b1", 32'h0000_1004, 4'b0111, 32'h0011_2233);
    #1;
    rst_n = 1'b0;
    #1;
    idle1("rsx_async", 1'b0);
    chk32("rsx_addr", bus1.mem_addr, 32'h0000_0000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      idle1("rsx_post", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
